text_cursor_ctrl: RTL and testbench



---
 rtl/text_cursor_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_text_cursor_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl
//   Buffers decoded ASCII key strobes and turns them into glyph draw
//   requests for a COLS x ROWS grid of CHAR_W x CHAR_H cells. It tracks the
//   text cursor and handles printable keys, newline, backspace and
//   clear-screen. Clear-screen sweeps every cell with a space.
//
// Ports
//   clk         system clock
//   reset_n     synchronous reset, active-high despite the name
//   key_valid   one-cycle strobe, key_ascii is a new keypress
//   key_ascii   ASCII code of the keypress
//   draw_ready  renderer can accept a draw request
//   draw_valid  draw request pending
//   draw_x      pixel x of cell origin (col * CHAR_W)
//   draw_y      pixel y of cell origin (row * CHAR_H)
//   draw_ascii  glyph to draw
//   cursor_col  current cursor column
//   cursor_row  current cursor row
//   busy        engine not idle, or keys still buffered
//   overflow    sticky: a key was dropped because the buffer was full
module text_cursor_ctrl #(
    parameter int unsigned COLS       = 20,
    parameter int unsigned ROWS       = 7,
    parameter int unsigned CHAR_W     = 8,
    parameter int unsigned CHAR_H     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [6:0] key_ascii,
    input  logic       draw_ready,
    output logic       draw_valid,
    output logic [8:0] draw_x,
    output logic [9:0] draw_y,
    output logic [6:0] draw_ascii,
    output logic [4:0] cursor_col,
    output logic [2:0] cursor_row,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned XSH = $clog2(CHAR_W);
    localparam int unsigned YSH = $clog2(CHAR_H);
    localparam logic [4:0] COL_MAX   = 5'(COLS - 1);
    localparam logic [2:0] ROW_MAX   = 3'(ROWS - 1);
    localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [6:0] ASCII_SPACE = 7'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DRAW_BS,
        S_CLEAR
    } state_e;

    // ---------------- key FIFO ----------------
    logic [6:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          fifo_empty, fifo_full, pop, push;
    logic [6:0]    head;

    state_e        state_q, state_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    assign head       = fifo_q[rd_ptr_q];
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    // A full FIFO still accepts a key when an entry leaves on the same edge.
    assign push       = key_valid && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= key_ascii;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (key_valid && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ---------------- cursor / draw FSM ----------------
    // The draw cell registers double as the sweep counters during CLEAR.
    logic [4:0] col_q, col_d, dcol_q, dcol_d;
    logic [2:0] row_q, row_d, drow_q, drow_d;
    logic [6:0] dasc_q, dasc_d;
    logic       xfer;

    assign draw_valid = (state_q != S_IDLE);
    assign xfer       = draw_valid && draw_ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dcol_d  = dcol_q;
        drow_d  = drow_q;
        dasc_d  = dasc_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head >= 7'h20 && head <= 7'h7E) begin
                        dcol_d  = col_q;
                        drow_d  = row_q;
                        dasc_d  = head;
                        state_d = S_DRAW;
                    end else if (head == 7'h0A || head == 7'h0D) begin
                        col_d = '0;
                        row_d = (row_q == ROW_MAX) ? '0 : row_q + 3'd1;
                    end else if (head == 7'h08) begin
                        if (col_q != '0) begin
                            col_d = col_q - 5'd1;
                        end else if (row_q != '0) begin
                            row_d = row_q - 3'd1;
                            col_d = COL_MAX;
                        end
                        dcol_d  = col_d;
                        drow_d  = row_d;
                        dasc_d  = ASCII_SPACE;
                        state_d = S_DRAW_BS;
                    end else if (head == 7'h0C) begin
                        dcol_d  = '0;
                        drow_d  = '0;
                        dasc_d  = ASCII_SPACE;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DRAW: begin
                if (xfer) begin
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = (row_q == ROW_MAX) ? '0 : row_q + 3'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_DRAW_BS: begin
                if (xfer) begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (xfer) begin
                    if (dcol_q == COL_MAX && drow_q == ROW_MAX) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else if (dcol_q == COL_MAX) begin
                        dcol_d = '0;
                        drow_d = drow_q + 3'd1;
                    end else begin
                        dcol_d = dcol_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            dcol_q  <= '0;
            drow_q  <= '0;
            dasc_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dcol_q  <= dcol_d;
            drow_q  <= drow_d;
            dasc_q  <= dasc_d;
        end
    end

    assign draw_x     = 9'(dcol_q) << XSH;
    assign draw_y     = 10'(drow_q) << YSH;
    assign draw_ascii = dasc_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = draw_valid || !fifo_empty;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
module tb_text_cursor_ctrl;

    localparam int COLS = 20;
    localparam int ROWS = 7;
    localparam int CW   = 8;
    localparam int CH   = 16;
    localparam int FD   = 4;

    logic       clk;
    logic       reset_n;
    logic       key_valid;
    logic [6:0] key_ascii;
    logic       draw_ready;
    logic       draw_valid;
    logic [8:0] draw_x;
    logic [9:0] draw_y;
    logic [6:0] draw_ascii;
    logic [4:0] cursor_col;
    logic [2:0] cursor_row;
    logic       busy;
    logic       overflow;

    text_cursor_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .CHAR_H(CH), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_ascii(key_ascii),
        .draw_ready(draw_ready), .draw_valid(draw_valid), .draw_x(draw_x),
        .draw_y(draw_y), .draw_ascii(draw_ascii), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference model (screen-level) ----------------
    typedef struct { int x; int y; int c; } draw_t;
    draw_t      exp_q[$];
    logic [6:0] kq[$];
    int         pending = 0;   // draws the engine still owes for the key in hand
    int         mc = 0, mr = 0;
    bit         ovf = 0;
    bit         mon_en = 0;
    int         xfer_cnt = 0;
    int         last_x = -1, last_y = -1, last_c = -1;

    task automatic apply_key(input logic [6:0] k);
        if (k >= 7'h20 && k <= 7'h7E) begin
            exp_q.push_back('{mc * CW, mr * CH, int'(k)});
            pending = 1;
            mc++;
            if (mc == COLS) begin mc = 0; mr = (mr + 1) % ROWS; end
        end else if (k == 7'h0A || k == 7'h0D) begin
            mc = 0;
            mr = (mr + 1) % ROWS;
        end else if (k == 7'h08) begin
            if (mc > 0) mc--;
            else if (mr > 0) begin mr--; mc = COLS - 1; end
            exp_q.push_back('{mc * CW, mr * CH, 32});
            pending = 1;
        end else if (k == 7'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    exp_q.push_back('{c * CW, r * CH, 32});
            pending = COLS * ROWS;
            mc = 0;
            mr = 0;
        end
    endtask

    // Monitor: compares what the DUT presents now, then advances the model
    // through the edge that follows.
    always @(negedge clk) begin
        bit idle;
        if (mon_en) begin
            chk("draw_valid", draw_valid, 32'(pending != 0));
            if (draw_valid === 1'b1) begin
                chk("expected_draw_available", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("draw_x", draw_x, exp_q[0].x);
                    chk("draw_y", draw_y, exp_q[0].y);
                    chk("draw_ascii", draw_ascii, exp_q[0].c);
                end
                if (draw_ready) begin
                    xfer_cnt++;
                    last_x = int'(draw_x);
                    last_y = int'(draw_y);
                    last_c = int'(draw_ascii);
                end
            end
            chk("busy", busy, 32'(pending != 0 || kq.size() != 0));
            chk("overflow", overflow, 32'(ovf));
            if (pending == 0 && kq.size() == 0) begin
                chk("cursor_col", cursor_col, mc);
                chk("cursor_row", cursor_row, mr);
            end
        end
        if (reset_n) begin
            kq.delete();
            exp_q.delete();
            pending = 0;
            mc = 0;
            mr = 0;
            ovf = 0;
        end else begin
            idle = (pending == 0);
            if (pending != 0 && draw_ready) begin
                void'(exp_q.pop_front());
                pending--;
            end
            if (idle && kq.size() > 0) apply_key(kq.pop_front());
            if (key_valid) begin
                if (kq.size() < FD) kq.push_back(key_ascii);
                else ovf = 1;
            end
        end
    end

    // ---------------- ready driver ----------------
    int rmode = 1;  // 0: stalled, 1: always ready, 2: random
    initial begin
        draw_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       draw_ready = 1'b0;
                1:       draw_ready = 1'b1;
                default: draw_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] k);
        key_valid = 1'b1;
        key_ascii = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        repeat (2) tick();
        reset_n = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("idle_within_budget", busy, 0);
    endtask

    initial begin
        int base;
        int r;
        reset_n   = 1'b1;
        key_valid = 1'b0;
        key_ascii = '0;
        // keys strobed during reset must be ignored
        repeat (3) begin
            key_valid = 1'b1;
            key_ascii = 7'h41;
            tick();
        end
        key_valid = 1'b0;
        reset_n   = 1'b0;
        chk("rst_draw_valid", draw_valid, 0);
        chk("rst_draw_x", draw_x, 0);
        chk("rst_draw_y", draw_y, 0);
        chk("rst_draw_ascii", draw_ascii, 0);
        chk("rst_cursor_col", cursor_col, 0);
        chk("rst_cursor_row", cursor_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        mon_en = 1;

        // single key: draw_valid appears two edges after the strobe edge
        press(7'h41);
        chk("lat_edge1_valid", draw_valid, 0);
        tick();
        chk("lat_edge2_valid", draw_valid, 1);
        chk("lat_x", draw_x, 0);
        chk("lat_y", draw_y, 0);
        chk("lat_ascii", draw_ascii, 7'h41);
        wait_idle(20);
        chk("a_cursor_col", cursor_col, 1);
        chk("a_cursor_row", cursor_row, 0);

        // 21 printable keys: row wrap at the right edge
        do_reset();
        base = xfer_cnt;
        for (int i = 0; i < 21; i++) begin
            press(7'(8'h41 + i));
            tick();
        end
        wait_idle(50);
        chk("row_wrap_xfers", xfer_cnt - base, 21);
        chk("row_wrap_last_x", last_x, 0);
        chk("row_wrap_last_y", last_y, 16);
        chk("row_wrap_col", cursor_col, 1);
        chk("row_wrap_row", cursor_row, 1);

        // backspace across a row boundary, then at the origin
        press(7'h08);
        wait_idle(20);
        press(7'h08);
        wait_idle(20);
        chk("bs_wrap_x", last_x, 152);
        chk("bs_wrap_y", last_y, 0);
        chk("bs_wrap_c", last_c, 32);
        chk("bs_wrap_col", cursor_col, 19);
        chk("bs_wrap_row", cursor_row, 0);
        do_reset();
        press(7'h08);
        wait_idle(20);
        chk("bs_origin_x", last_x, 0);
        chk("bs_origin_y", last_y, 0);
        chk("bs_origin_col", cursor_col, 0);
        chk("bs_origin_row", cursor_row, 0);

        // stalled renderer: buffer fills, extra keys dropped
        rmode = 0;
        tick();
        tick();
        base = xfer_cnt;
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key_ascii = 7'(8'h61 + i);
            tick();
        end
        key_valid = 1'b0;
        repeat (3) tick();
        chk("stall_overflow", overflow, 1);
        chk("stall_valid_held", draw_valid, 1);
        chk("stall_no_xfer", xfer_cnt - base, 0);
        rmode = 1;
        wait_idle(50);
        chk("stall_xfers", xfer_cnt - base, 1 + FD);

        // clear-screen with a randomly stalling renderer
        do_reset();
        press(7'h58);
        press(7'h59);
        wait_idle(20);
        rmode = 2;
        base = xfer_cnt;
        press(7'h0C);
        wait_idle(3000);
        chk("clear_xfers", xfer_cnt - base, COLS * ROWS);
        chk("clear_last_x", last_x, 152);
        chk("clear_last_y", last_y, 96);
        chk("clear_last_c", last_c, 32);
        chk("clear_col", cursor_col, 0);
        chk("clear_row", cursor_row, 0);

        // carriage return on the last row wraps to the top without drawing
        rmode = 1;
        for (int i = 0; i < 6; i++) press(7'h0A);
        for (int i = 0; i < 5; i++) begin
            press(7'h30);
            tick();
        end
        wait_idle(50);
        chk("pre_cr_col", cursor_col, 5);
        chk("pre_cr_row", cursor_row, 6);
        base = xfer_cnt;
        press(7'h0D);
        wait_idle(20);
        chk("cr_col", cursor_col, 0);
        chk("cr_row", cursor_row, 0);
        chk("cr_no_draw", xfer_cnt - base, 0);

        // reset in the middle of a clear sweep
        press(7'h0C);
        repeat (20) tick();
        chk("mid_clear_active", draw_valid, 1);
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        chk("mid_rst_valid", draw_valid, 0);
        chk("mid_rst_col", cursor_col, 0);
        chk("mid_rst_row", cursor_row, 0);
        chk("mid_rst_busy", busy, 0);

        // random traffic against the model
        rmode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 99));
                key_valid = 1'b1;
                if (r < 70)      key_ascii = 7'($urandom_range(32, 126));
                else if (r < 80) key_ascii = 7'h08;
                else if (r < 85) key_ascii = 7'h0A;
                else if (r < 89) key_ascii = 7'h0D;
                else if (r < 91) key_ascii = 7'h0C;
                else if (r < 94) key_ascii = 7'h1B;
                else if (r < 97) key_ascii = 7'h7F;
                else             key_ascii = 7'h09;
            end else begin
                key_valid = 1'b0;
            end
            tick();
        end
        key_valid = 1'b0;
        wait_idle(8000);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
